// File: rtl/dft_wb_arbiter.sv
// dft_wb_arbiter: round-robin two-master Wishbone arbiter with timeout abort (m0/m1 in, s out, grant_o, timeout_cnt_o)
module dft_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic [7:0]  timeout_cnt_o
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;
  state_t      r_state;
  logic        r_last;
  logic        r_abort_m;
  logic [15:0] r_wait;
  logic [7:0]  r_tocnt;
  logic        w_g0, w_g1, w_gnt, w_cyc, w_stb, w_resp, w_to, w_pick1;
  always_comb begin
    w_g0    = r_state == GRANT0;
    w_g1    = r_state == GRANT1;
    w_gnt   = w_g0 | w_g1;
    w_cyc   = w_g1 ? m1_cyc_i : m0_cyc_i;
    w_stb   = w_g1 ? m1_stb_i : m0_stb_i;
    w_resp  = s_ack_i | s_err_i;
    w_to    = w_gnt & w_cyc & w_stb & ~w_resp & (r_wait == 16'(TIMEOUT));
    w_pick1 = m1_cyc_i & (~m0_cyc_i | ~r_last);
    s_cyc_o = w_gnt & w_cyc;
    s_stb_o = w_gnt & w_stb;
    s_we_o  = w_gnt & (w_g1 ? m1_we_i : m0_we_i);
    s_adr_o = w_g1 ? m1_adr_i : w_g0 ? m0_adr_i : '0;
    s_dat_o = w_g1 ? m1_dat_i : w_g0 ? m0_dat_i : '0;
    s_sel_o = w_g1 ? m1_sel_i : w_g0 ? m0_sel_i : '0;
    m0_ack_o = w_g0 & s_ack_i;
    m1_ack_o = w_g1 & s_ack_i;
    m0_err_o = (w_g0 & s_err_i) | (r_state == ABORT & ~r_abort_m);
    m1_err_o = (w_g1 & s_err_i) | (r_state == ABORT & r_abort_m);
    m0_dat_o = w_g0 ? s_dat_i : '0;
    m1_dat_o = w_g1 ? s_dat_i : '0;
    grant_o  = {w_g1, w_g0};
    timeout_cnt_o = r_tocnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_abort_m <= 1'b0;
      r_wait    <= '0;
      r_tocnt   <= '0;
    end else begin
      r_wait <= (w_gnt & w_cyc & w_stb & ~w_resp & ~w_to) ? r_wait + 16'd1 : '0;
      case (r_state)
        IDLE: if (m0_cyc_i | m1_cyc_i) begin
          r_state <= w_pick1 ? GRANT1 : GRANT0;
          r_last  <= w_pick1;
        end
        ABORT: begin
          r_state <= IDLE;
          r_tocnt <= r_tocnt + 8'(r_tocnt != 8'hff);
        end
        default: if (!w_cyc) r_state <= IDLE;
        else if (w_to) begin
          r_state   <= ABORT;
          r_abort_m <= w_g1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dft_wb_arbiter.sv
// tb_dft_wb_arbiter: randomized cycle-level checks of dft_wb_arbiter against a behavioural model
module tb_dft_wb_arbiter;
  localparam int TO = 8;
  logic        clk = 0;
  logic        rst_n;
  logic        cyc [2], stb [2], we [2];
  logic [31:0] adr [2], wdat [2];
  logic [3:0]  sel [2];
  logic [31:0] m_dat [2];
  logic        m_ack [2], m_err [2];
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, sdat;
  logic [3:0]  s_sel;
  logic        ack, err;
  logic [1:0]  grant;
  logic [7:0]  tocnt;
  int n_vec = 0, n_bad = 0;
  int m_own, m_ab, m_last, m_wait, m_to, stall;
  always #5 clk = ~clk;
  dft_wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_dat_o(m_dat[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_dat_o(m_dat[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_dat_i(sdat), .s_ack_i(ack), .s_err_i(err), .grant_o(grant), .timeout_cnt_o(tocnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = -1; m_ab = 0; m_last = 1; m_wait = 0; m_to = 0;
  endtask
  task automatic check_all();
    int g;
    g = (m_own == 0 || m_own == 1) ? m_own : -1;
    chk("s_cyc", s_cyc, g >= 0 ? cyc[g] : 1'b0);
    chk("s_stb", s_stb, g >= 0 ? stb[g] : 1'b0);
    chk("s_we",  s_we,  g >= 0 ? we[g]  : 1'b0);
    chk("s_adr", s_adr, g >= 0 ? adr[g] : 32'h0);
    chk("s_dat", s_wdat, g >= 0 ? wdat[g] : 32'h0);
    chk("s_sel", s_sel, g >= 0 ? sel[g] : 4'h0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ack", i), m_ack[i], g == i && ack);
      chk($sformatf("m%0d_err", i), m_err[i], (g == i && err) || (m_own == 2 && m_ab == i));
      chk($sformatf("m%0d_dat", i), m_dat[i], g == i ? sdat : 32'h0);
    end
    chk("grant", grant, g >= 0 ? 2'(1 << g) : 2'b00);
    chk("tocnt", tocnt, m_to);
  endtask
  task automatic model_update();
    if (m_own == -1) begin
      if (cyc[0] || cyc[1]) begin
        m_own = (cyc[0] && cyc[1]) ? 1 - m_last : (cyc[1] ? 1 : 0);
        m_last = m_own;
      end
    end else if (m_own == 2) begin
      if (m_to < 255) m_to++;
      m_own = -1;
    end else if (!cyc[m_own]) begin
      m_own = -1; m_wait = 0;
    end else if (stb[m_own] && !ack && !err) begin
      if (m_wait == TO) begin m_ab = m_own; m_own = 2; m_wait = 0; end
      else m_wait++;
    end else m_wait = 0;
  endtask
  task automatic gen(input int mode);
    for (int i = 0; i < 2; i++) begin
      if (mode == 0) begin
        cyc[i] = cyc[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        stb[i] = cyc[i] && (stb[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1));
      end else begin
        cyc[i] = (i == 0);
        stb[i] = (i == 0);
      end
      we[i] = $urandom_range(0, 1); adr[i] = $urandom; wdat[i] = $urandom; sel[i] = 4'($urandom);
    end
    sdat = $urandom;
    if (mode == 1) begin ack = 0; err = 0; end
    else if (mode == 2) begin ack = (m_own == 0 && m_wait == TO); err = 0; end
    else if (stall > 0) begin stall--; ack = 0; err = 0; end
    else begin
      if ($urandom_range(0, 29) == 0) stall = 12;
      ack = $urandom_range(0, 2) == 0;
      err = !ack && $urandom_range(0, 15) == 0;
    end
  endtask
  task automatic step(input int mode);
    gen(mode);
    #3;
    check_all();
    if (mode == 0 && $urandom_range(0, 199) == 0) begin
      rst_n = 0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1 rst_n = 1;
    end else begin
      @(posedge clk);
      model_update();
      #1;
    end
  endtask
  initial begin
    rst_n = 0; stall = 0; ack = 0; err = 0; sdat = 0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; wdat[i] = 0; sel[i] = 0;
    end
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 4000; c++) step(0);
    for (int c = 0; c < 300; c++) step(2);
    for (int c = 0; c < 3100; c++) step(1);
    chk("tocnt_sat", tocnt, 8'd255);
    for (int c = 0; c < 2000; c++) step(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
